// File: rtl/attn_sched_pkg.sv
// Shared types and constants for the attention row scheduler and its output FIFO.
package attn_sched_pkg;

   localparam int ERST_CYCLES = 2;

   // Entry fields are sized for the widest configuration the scheduler supports (16 bits each).
   localparam int ENTRY_DATA_W = 16;
   localparam int ENTRY_ROW_W  = 16;
   localparam int ENTRY_COL_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ERST   = 3'd1,
      S_WSPACE = 3'd2,
      S_START  = 3'd3,
      S_RUN    = 3'd4,
      S_FLUSH  = 3'd5
   } sched_state_e;

   typedef struct packed {
      logic [ENTRY_DATA_W-1:0] data;
      logic [ENTRY_ROW_W-1:0]  row;
      logic [ENTRY_COL_W-1:0]  col;
      logic                    last;
   } sched_entry_t;

endpackage

// File: rtl/sched_out_fifo.sv
// Synchronous FIFO with a free-entry count; a push into a full FIFO is accepted only alongside a pop.
module sched_out_fifo #(
   parameter int  DEPTH   = 256,
   parameter type entry_t = logic [7:0],
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  entry_t           push_data,
   input  logic             pop,
   output entry_t           head,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] free
);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign free    = CNT_W'(DEPTH) - count;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; empty/count guard every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/attn_row_scheduler.sv
// Row-by-row sequencer for the fused QK^T+softmax engine with a buffered output stream.
// Define ATTN_SCHED_PERF_CNT_EN to add the perf_cycles/perf_stall/perf_rows counters.
module attn_row_scheduler
   import attn_sched_pkg::*;
#(
   parameter int D_K               = 64,
   parameter int MAX_NUM_QUERIES   = 256,
   parameter int MAX_ROWS          = 256,
   parameter int SOFTMAX_OUT_WIDTH = 12,
   parameter int FIFO_DEPTH        = 256,
   parameter int IDX_W             = $clog2(MAX_NUM_QUERIES),
   parameter int ROW_W             = $clog2(MAX_ROWS),
   parameter int DK_W              = $clog2(D_K)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_start,
   input  logic [ROW_W:0]               cfg_num_rows,
   input  logic [IDX_W:0]               cfg_num_keys,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic                         eng_rst_,
   output logic                         eng_start,
   output logic [IDX_W:0]               eng_num_keys,
   input  logic [DK_W-1:0]              eng_dk_idx,
   input  logic [IDX_W:0]               eng_key_idx,
   input  logic                         eng_valid,
   input  logic [SOFTMAX_OUT_WIDTH-1:0] eng_softmax,
   input  logic                         eng_done,
   output logic [ROW_W+DK_W-1:0]        q_addr,
   output logic [IDX_W+DK_W-1:0]        k_addr,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SOFTMAX_OUT_WIDTH-1:0] out_data,
   output logic [ROW_W-1:0]             out_row,
   output logic [IDX_W-1:0]             out_col,
   output logic                         out_last
`ifdef ATTN_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]                  perf_cycles,
   output logic [31:0]                  perf_stall,
   output logic [ROW_W:0]               perf_rows
`endif
);

   localparam int             FREE_W    = $clog2(FIFO_DEPTH + 1);
   localparam int             CMP_W     = (FREE_W > IDX_W + 1) ? FREE_W : IDX_W + 1;
   localparam logic [IDX_W:0] MAX_KEYS  = (IDX_W + 1)'(MAX_NUM_QUERIES);
   localparam logic [1:0]     ERST_LAST = 2'(ERST_CYCLES - 1);

   sched_state_e      state;
   logic [ROW_W:0]    num_rows_q;
   logic [ROW_W:0]    row_cnt;
   logic [IDX_W:0]    num_keys_q;
   logic [IDX_W:0]    col_cnt;
   logic [IDX_W:0]    col_next;
   logic [1:0]        erst_cnt;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              cfg_bad;
   logic              push;
   logic              push_drop;
   logic              last_row;
   logic              fifo_empty;
   logic              fifo_full;
   logic              space_ok;
   logic [FREE_W-1:0] fifo_free;
   sched_entry_t      push_entry;
   sched_entry_t      head;
   logic              unused_bits;

   assign cfg_bad   = (cfg_num_keys == '0) || (cfg_num_keys > MAX_KEYS);
   assign push      = (state == S_RUN) & eng_valid;
   assign push_drop = push & fifo_full & ~out_ready;
   assign col_next  = col_cnt + {{IDX_W{1'b0}}, eng_valid};
   assign last_row  = ((row_cnt + 1'b1) == num_rows_q);
   assign space_ok  = CMP_W'(fifo_free) >= CMP_W'(num_keys_q);

   assign push_entry.data = ENTRY_DATA_W'(eng_softmax);
   assign push_entry.row  = ENTRY_ROW_W'(row_cnt[ROW_W-1:0]);
   assign push_entry.col  = ENTRY_COL_W'(col_cnt[IDX_W-1:0]);
   assign push_entry.last = (col_cnt == num_keys_q - 1'b1);

   // D_K is a power of two, so row*D_K + dk is a plain concatenation.
   assign q_addr = {row_cnt[ROW_W-1:0], eng_dk_idx};
   assign k_addr = {eng_key_idx[IDX_W-1:0], eng_dk_idx};

   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign eng_num_keys = num_keys_q;
   assign eng_start    = (state == S_START);
   assign eng_rst_     = (state == S_WSPACE) | (state == S_START) | (state == S_RUN);

   sched_out_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (sched_entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (out_ready),
      .head      (head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .free      (fifo_free)
   );

   // Head storage is uninitialised after reset, so the data outputs are held at zero while empty.
   assign out_valid = ~fifo_empty;
   assign out_data  = out_valid ? SOFTMAX_OUT_WIDTH'(head.data) : '0;
   assign out_row   = out_valid ? ROW_W'(head.row) : '0;
   assign out_col   = out_valid ? IDX_W'(head.col) : '0;
   assign out_last  = out_valid & head.last;

   assign unused_bits = ^{eng_key_idx[IDX_W], head};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         num_rows_q <= '0;
         num_keys_q <= '0;
         row_cnt    <= '0;
         col_cnt    <= '0;
         erst_cnt   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (push_drop) err_q <= 1'b1;
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  num_rows_q <= cfg_num_rows;
                  num_keys_q <= cfg_num_keys;
                  row_cnt    <= '0;
                  col_cnt    <= '0;
                  erst_cnt   <= '0;
                  err_q      <= 1'b0;
                  if (cfg_num_rows == '0) begin
                     busy_q <= 1'b1;
                     state  <= S_FLUSH;
                  end else if (cfg_bad) begin
                     err_q  <= 1'b1;
                     done_q <= 1'b1;
                  end else begin
                     busy_q <= 1'b1;
                     state  <= S_ERST;
                  end
               end
            end
            S_ERST: begin
               if (erst_cnt == ERST_LAST) state <= S_WSPACE;
               else                       erst_cnt <= erst_cnt + 1'b1;
            end
            S_WSPACE: begin
               if (space_ok) state <= S_START;
            end
            S_START: state <= S_RUN;
            S_RUN: begin
               col_cnt <= col_next;
               if (eng_done) begin
                  if (col_next != num_keys_q) err_q <= 1'b1;
                  row_cnt  <= row_cnt + 1'b1;
                  col_cnt  <= '0;
                  erst_cnt <= '0;
                  state    <= last_row ? S_FLUSH : S_ERST;
               end
            end
            S_FLUSH: begin
               if (fifo_empty) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ATTN_SCHED_PERF_CNT_EN
   logic stall_cycle;

   assign stall_cycle = (state == S_WSPACE) | ((state == S_FLUSH) & ~fifo_empty & ~out_ready);

   // Saturating job statistics, restarted by every accepted cfg_start.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
         perf_rows   <= '0;
      end else if ((state == S_IDLE) && cfg_start) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
         perf_rows   <= '0;
      end else begin
         if (busy_q && (perf_cycles != '1))                 perf_cycles <= perf_cycles + 1'b1;
         if (stall_cycle && (perf_stall != '1))             perf_stall  <= perf_stall + 1'b1;
         if ((state == S_RUN) && eng_done && (perf_rows != '1)) perf_rows <= perf_rows + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_attn_row_scheduler.sv
// Self-checking bench: randomized engine/consumer models against a queue-based reference of the output stream.
module tb_attn_row_scheduler;

   localparam int D_K        = 64;
   localparam int MAXQ       = 8;
   localparam int MAX_ROWS   = 256;
   localparam int SW         = 12;
   localparam int FIFO_DEPTH = 8;
   localparam int IDX_W      = $clog2(MAXQ);
   localparam int ROW_W      = $clog2(MAX_ROWS);
   localparam int DK_W       = $clog2(D_K);

   logic                   clk;
   logic                   rst;
   logic                   cfg_start;
   logic [ROW_W:0]         cfg_num_rows;
   logic [IDX_W:0]         cfg_num_keys;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic                   eng_rst_;
   logic                   eng_start;
   logic [IDX_W:0]         eng_num_keys;
   logic [DK_W-1:0]        eng_dk_idx;
   logic [IDX_W:0]         eng_key_idx;
   logic                   eng_valid;
   logic [SW-1:0]          eng_softmax;
   logic                   eng_done;
   logic [ROW_W+DK_W-1:0]  q_addr;
   logic [IDX_W+DK_W-1:0]  k_addr;
   logic                   out_valid;
   logic                   out_ready;
   logic [SW-1:0]          out_data;
   logic [ROW_W-1:0]       out_row;
   logic [IDX_W-1:0]       out_col;
   logic                   out_last;
`ifdef ATTN_SCHED_PERF_CNT_EN
   logic [31:0]            perf_cycles;
   logic [31:0]            perf_stall;
   logic [ROW_W:0]         perf_rows;
`endif

   attn_row_scheduler #(
      .D_K               (D_K),
      .MAX_NUM_QUERIES   (MAXQ),
      .MAX_ROWS          (MAX_ROWS),
      .SOFTMAX_OUT_WIDTH (SW),
      .FIFO_DEPTH        (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_start    (cfg_start),
      .cfg_num_rows (cfg_num_rows),
      .cfg_num_keys (cfg_num_keys),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .eng_rst_     (eng_rst_),
      .eng_start    (eng_start),
      .eng_num_keys (eng_num_keys),
      .eng_dk_idx   (eng_dk_idx),
      .eng_key_idx  (eng_key_idx),
      .eng_valid    (eng_valid),
      .eng_softmax  (eng_softmax),
      .eng_done     (eng_done),
      .q_addr       (q_addr),
      .k_addr       (k_addr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_row      (out_row),
      .out_col      (out_col),
      .out_last     (out_last)
`ifdef ATTN_SCHED_PERF_CNT_EN
      ,
      .perf_cycles  (perf_cycles),
      .perf_stall   (perf_stall),
      .perf_rows    (perf_rows)
`endif
   );

   typedef struct {
      int data;
      int row;
      int col;
      int last;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   job_keys = 1;
   int   short_by = 0;
   int   row_idx = 0;
   int   start_cnt = 0;
   int   pop_cnt = 0;
   int   done_cnt = 0;
   int   done_base = 0;
   int   ready_mode = 1;
   int   emit_cnt = 0;
   int   wait_cnt = 0;
   int   low_run = 0;
   int   last_low_run = 0;
   bit   eng_active = 0;
   exp_t exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Engine model: one row of softmax samples with random gaps after each start, then a sticky done.
   always @(negedge clk) begin
      if (!rst && eng_rst_ && eng_valid) begin
         check_output("q_addr", q_addr, row_idx * D_K + int'(eng_dk_idx));
         check_output("k_addr", k_addr, int'(eng_key_idx) * D_K + int'(eng_dk_idx));
      end
      eng_valid = 1'b0;
      if (rst || !eng_rst_) begin
         eng_active = 0;
         eng_done   = 1'b0;
         low_run++;
      end else begin
         if (low_run > 0) begin
            last_low_run = low_run;
            low_run      = 0;
         end
         if (eng_start) begin
            row_idx = start_cnt;
            start_cnt++;
            check_output("eng_num_keys", eng_num_keys, job_keys);
            if (start_cnt > 1) check_output("erst_len", last_low_run, 2);
            eng_active = 1;
            emit_cnt   = 0;
            wait_cnt   = $urandom_range(0, 2);
         end else if (eng_active) begin
            if (emit_cnt < job_keys - short_by) begin
               if (wait_cnt == 0) begin
                  eng_dk_idx  = (row_idx == 3) ? DK_W'(7) : DK_W'($urandom_range(0, D_K - 1));
                  eng_key_idx = (row_idx == 3) ? (IDX_W + 1)'(5) : (IDX_W + 1)'($urandom_range(0, MAXQ - 1));
                  eng_softmax = SW'($urandom_range(0, 4095));
                  eng_valid   = 1'b1;
                  exp_q.push_back('{int'(eng_softmax), row_idx, emit_cnt, int'(emit_cnt == job_keys - 1)});
                  emit_cnt++;
                  wait_cnt = $urandom_range(0, 2);
               end else begin
                  wait_cnt--;
               end
            end else begin
               eng_done   = 1'b1;
               eng_active = 0;
            end
         end
      end
   end

   // Consumer: drives out_ready and compares every accepted head entry with the reference queue.
   always @(negedge clk) begin
      exp_t e;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_out", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_output("out_data", out_data, e.data);
            check_output("out_row", out_row, e.row);
            check_output("out_col", out_col, e.col);
            check_output("out_last", out_last, e.last);
         end
         pop_cnt++;
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
   end

   task automatic apply_stimulus(input int rows, input int keys);
      job_keys     = keys;
      start_cnt    = 0;
      pop_cnt      = 0;
      done_base    = done_cnt;
      cfg_num_rows = (ROW_W + 1)'(rows);
      cfg_num_keys = (IDX_W + 1)'(keys);
      cfg_start    = 1'b1;
      @(negedge clk);
      cfg_start    = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound, input int exp_pops);
      int seen = 0;
      for (int i = 0; i < bound && seen == 0; i++) begin
         if (done) seen = 1;
         else @(negedge clk);
      end
      check_output({tag, "_done_seen"}, seen, 1);
      if (seen == 1) check_output({tag, "_pops_at_done"}, pop_cnt, exp_pops);
   endtask

   task automatic check_job(input string tag, input int exp_pops, input int exp_starts, input int exp_err);
      repeat (2) @(negedge clk);
      check_output({tag, "_pops"}, pop_cnt, exp_pops);
      check_output({tag, "_starts"}, start_cnt, exp_starts);
      check_output({tag, "_err"}, err, exp_err);
      check_output({tag, "_busy"}, busy, 0);
      check_output({tag, "_done_pulses"}, done_cnt - done_base, 1);
      check_output({tag, "_leftover"}, exp_q.size(), 0);
   endtask

   initial begin
      int rows;
      int keys;
      int seen;
      rst          = 1'b1;
      cfg_start    = 1'b0;
      cfg_num_rows = '0;
      cfg_num_keys = '0;
      eng_dk_idx   = '0;
      eng_key_idx  = '0;
      eng_valid    = 1'b0;
      eng_softmax  = '0;
      eng_done     = 1'b0;
      out_ready    = 1'b0;
      repeat (3) @(negedge clk);

      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_err", err, 0);
      check_output("rst_eng_rst_", eng_rst_, 0);
      check_output("rst_eng_start", eng_start, 0);
      check_output("rst_eng_num_keys", eng_num_keys, 0);
      check_output("rst_out_valid", out_valid, 0);
      check_output("rst_out_data", out_data, 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] two rows of four keys, consumer always ready");
      ready_mode = 1;
      apply_stimulus(2, 4);
      wait_done("basic", 500, 8);
      check_job("basic", 8, 2, 0);

      $display("[TB] back-pressure holds the scheduler waiting for space");
      ready_mode = 0;
      apply_stimulus(3, 6);
      repeat (50) @(negedge clk);
      check_output("bp_starts", start_cnt, 1);
      check_output("bp_pops", pop_cnt, 0);
      check_output("bp_busy", busy, 1);
      check_output("bp_err", err, 0);
      check_output("bp_eng_rst_", eng_rst_, 1);
      check_output("bp_eng_start", eng_start, 0);
      ready_mode = 1;
      wait_done("bp", 1000, 18);
      check_job("bp", 18, 3, 0);

      $display("[TB] illegal and empty configurations");
      apply_stimulus(2, 0);
      wait_done("keys0", 2, 0);
      check_job("keys0", 0, 0, 1);
      apply_stimulus(1, MAXQ + 1);
      wait_done("keys_big", 2, 0);
      check_job("keys_big", 0, 0, 1);
      apply_stimulus(0, 3);
      wait_done("rows0", 10, 0);
      check_job("rows0", 0, 0, 0);

      $display("[TB] four rows, random ready, fourth row drives fixed indices");
      ready_mode = 2;
      apply_stimulus(4, 3);
      wait_done("addr", 1000, 12);
      check_job("addr", 12, 4, 0);

      $display("[TB] engine reports done one sample early");
      short_by = 1;
      apply_stimulus(2, 3);
      wait_done("short", 500, 4);
      check_job("short", 4, 2, 1);
      short_by = 0;

      $display("[TB] cfg_start while busy is ignored");
      apply_stimulus(3, 5);
      for (int i = 0; i < 200 && start_cnt < 1; i++) @(negedge clk);
      cfg_num_rows = (ROW_W + 1)'(1);
      cfg_num_keys = (IDX_W + 1)'(1);
      cfg_start    = 1'b1;
      @(negedge clk);
      cfg_start    = 1'b0;
      wait_done("rebusy", 1500, 15);
      check_job("rebusy", 15, 3, 0);

      $display("[TB] reset in the middle of row 1");
      ready_mode = 0;
      apply_stimulus(3, 3);
      seen = 0;
      for (int i = 0; i < 300 && seen == 0; i++) begin
         if (start_cnt == 2 && eng_active) seen = 1;
         else @(negedge clk);
      end
      check_output("midrst_reached_row1", seen, 1);
      rst = 1'b1;
      @(negedge clk);
      check_output("midrst_out_valid", out_valid, 0);
      check_output("midrst_busy", busy, 0);
      check_output("midrst_eng_rst_", eng_rst_, 0);
      check_output("midrst_done", done, 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      check_output("midrst_no_done", done_cnt - done_base, 0);
      ready_mode = 1;
      apply_stimulus(2, 4);
      wait_done("after_rst", 500, 8);
      check_job("after_rst", 8, 2, 0);

      $display("[TB] random jobs");
      ready_mode = 2;
      for (int j = 0; j < 4; j++) begin
         rows = $urandom_range(1, 5);
         keys = $urandom_range(1, MAXQ);
         apply_stimulus(rows, keys);
         wait_done("rand", 3000, rows * keys);
         check_job("rand", rows * keys, rows, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/attn_row_scheduler.md
Name: attn_row_scheduler

Overview:
Sequences a full attention score matrix through the fused QKᵀ+softmax engine, one query row at a time. Per row it resets and starts the engine, drives the engine's key count, and generates Q/K operand-memory addresses from the engine's dk/key indices. It collects the engine's unstallable softmax stream into an output FIFO with a valid/ready interface, and gates each row start on FIFO space.

Parameters:
D_K, 64, feature dimension; must match the engine
MAX_NUM_QUERIES, 256, max keys per row; must match the engine
MAX_ROWS, 256, max query rows per job
SOFTMAX_OUT_WIDTH, 12, softmax sample width
FIFO_DEPTH, 256, output FIFO entries; must be >= MAX_NUM_QUERIES
IDX_W, $clog2(MAX_NUM_QUERIES), key index width
ROW_W, $clog2(MAX_ROWS), row index width
DK_W, $clog2(D_K), dk index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  job start pulse; ignored while busy
cfg_num_rows  in  ROW_W+1  query rows in job
cfg_num_keys  in  IDX_W+1  keys per row
busy  out  1  job in progress
done  out  1  one-cycle pulse when job complete
err  out  1  sticky; set on illegal config, cleared on next accepted cfg_start
eng_rst_  out  1  active-low reset to engine
eng_start  out  1  engine start pulse
eng_num_keys  out  IDX_W+1  latched cfg_num_keys
eng_dk_idx  in  DK_W  engine dk index
eng_key_idx  in  IDX_W+1  engine key index
eng_valid  in  1  engine softmax valid
eng_softmax  in  SOFTMAX_OUT_WIDTH  engine softmax sample
eng_done  in  1  engine all-outputs flag (sticky until engine reset)
q_addr  out  ROW_W+DK_W  Q memory address = row*D_K + eng_dk_idx
k_addr  out  IDX_W+DK_W  K memory address = eng_key_idx*D_K + eng_dk_idx
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer ready
out_data  out  SOFTMAX_OUT_WIDTH  softmax value
out_row  out  ROW_W  row of head entry
out_col  out  IDX_W  key column of head entry
out_last  out  1  head is last column of its row

Behaviour:
- Reset: all outputs 0 except eng_rst_ = 0; FSM enters IDLE; FIFO empty; counters 0.
- Operand memories are combinational-read. q_addr and k_addr are combinational from row_cnt and the engine indices. Multiplication by D_K is a left shift by DK_W.
- FSM states: IDLE, ERST, WSPACE, START, RUN, FLUSH.
- IDLE: on cfg_start, latch the config and set busy.
  - num_rows==0: go to FLUSH with no engine activity.
  - num_keys==0 or num_keys>MAX_NUM_QUERIES: set err, pulse done next cycle, stay IDLE.
- ERST: eng_rst_=0 for exactly 2 cycles, then WSPACE.
- WSPACE: wait until FIFO free entries >= num_keys, then go to START.
- START: eng_start=1 for 1 cycle, then RUN.
- RUN: every eng_valid cycle pushes {eng_softmax, row_cnt, col_cnt, col_cnt==num_keys-1} and increments col_cnt.
  - col_cnt is internal; the engine's softmax_idx is not used.
  - On eng_done, verify col_cnt==num_keys. On mismatch set err and continue.
  - Then row_cnt++ and col_cnt=0. Go to ERST if rows remain, else FLUSH.
- FLUSH: wait for FIFO empty, then pulse done, clear busy, go to IDLE. eng_rst_ stays 0 in IDLE.
- The WSPACE check guarantees a push never hits a full FIFO. If that invariant is violated, the push is dropped and err is set.
- FIFO: a pop (out_valid & out_ready) and a push in the same cycle are both honoured; occupancy is unchanged. out_* are driven from FIFO registers.
- cfg_start while busy has no effect.
- rst mid-job: everything is cleared immediately, FIFO contents are discarded, done does not pulse, and eng_rst_ goes to 0.

Optional Feature:
ATTN_SCHED_PERF_CNT_EN
- Defined: adds outputs perf_cycles[31:0] (cycles while busy), perf_stall[31:0] (cycles in WSPACE plus FLUSH cycles with out_valid & ~out_ready), and perf_rows[ROW_W:0]. All are cleared on an accepted cfg_start and saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package attn_sched_pkg holds:
  - the state enum sched_state_e;
  - the FIFO entry struct sched_entry_t {data, row, col, last};
  - the ERST_CYCLES=2 constant.
- One sub-module: sched_out_fifo, a synchronous FIFO with a free-count output, parameterized by depth and entry type.

Test Plan:
- rows=2, keys=4, D_K=64, out_ready=1 -> exactly 8 outputs; row 0 cols 0..3 then row 1 cols 0..3; out_last on cols 3; one done pulse after the last pop; 2 eng_start pulses, each preceded by 2 eng_rst_ low cycles.
- Address check with row_cnt=3, eng_key_idx=5, eng_dk_idx=7 -> q_addr=199, k_addr=327.
- FIFO_DEPTH=8, keys=6, rows=3, out_ready=0 for 50 cycles -> FSM holds in WSPACE after row 1; no drops; err=0; all 18 outputs in order once ready is released.
- cfg_num_keys=0 -> err=1, done pulses within 2 cycles, eng_start never asserted; cfg_num_rows=0 -> done pulses, err=0, no outputs.
- rst asserted mid-RUN in row 1 -> next cycle out_valid=0, busy=0, eng_rst_=0; a new job then completes normally.
- cfg_start re-pulsed while busy -> ignored; output count unchanged.
